aes_key_sched: RTL and testbench
================================

# aes_key_sched

Iterative, parametrised AES key-expansion engine: the sequential successor to the fully combinational AES-128 key generator. It supports AES-128, AES-192 and AES-256 through one parameter. It generates one 32-bit schedule word per clock using a single shared 4-byte SubWord (four `sbox1` instances) and stores the full schedule in an internal word store. The cipher datapath reads round keys back by round index through a registered read port.

## Interface
- `KEY_BITS`, default 128; key length, one of 128 / 192 / 256 (other values are a elaboration error).
- `NK` (derived) = KEY_BITS/32, giving 4 / 6 / 8.
- `NR` (derived) = NK+6, giving 10 / 12 / 14.
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: request expansion of `key_in`; accepted only when `busy`=0.
- `key_in` in 256: cipher key, MSB-aligned; bits [255:256-KEY_BITS] are used and the rest are ignored.
- `busy` out 1: expansion in progress.
- `done` out 1: one-cycle pulse when the schedule is complete.
- `key_ready` out 1: schedule is valid and readable; held until the next accepted `start` or `rst`.
- `rd_en` in 1: round-key read request.
- `rd_round` in 4: round index, 0..NR.
- `rd_key` out 128: round key {w[4r], w[4r+1], w[4r+2], w[4r+3]}.
- `rd_valid` out 1: `rd_key` is valid this cycle.

## Operation
- Word store: 4*(NR+1) × 32 bits (44 / 52 / 60 words). Written only by the engine and not cleared by `rst`.
- Accepted `start` (edge E0):
  - w[0..NK-1] ← key words, MSW first.
  - i ← NK, rcon ← 8'h01.
  - busy ← 1, key_ready ← 0.
- `start` while busy=1 is ignored; there is no restart.
- GEN state: one word per cycle, w[i] = w[i-NK] ^ t. The term t is:
  - i mod NK == 0: SubWord(RotWord(w[i-1])) ^ {rcon, 24'h0}; then rcon ← xtime(rcon), i.e. {rcon[6:0],1'b0} ^ (rcon[7] ? 8'h1b : 0).
  - NK==8 and i mod 8 == 4: SubWord(w[i-1]), with no rotate and no rcon.
  - otherwise: w[i-1].
- w[i-1] and w[i-NK] come from shadow registers (last NK words), not from the store read path.
- State machine IDLE → GEN → IDLE.
  - GEN exits after writing word 4*NR+3.
  - The next cycle drives done=1 and key_ready=1, and busy falls to 0 in that same cycle.
- Read port: registered, one request per cycle, fully pipelined.
  - rd_en at edge E produces rd_key/rd_valid at edge E+1.
  - rd_valid = rd_en & key_ready, sampled at E.
  - If rd_round > NR, or key_ready=0: rd_key = 128'h0 and rd_valid = 0.
- Reset values: busy=0, done=0, key_ready=0, rd_valid=0, rd_key=0, rcon=8'h01, state IDLE.

## Timing
- Key load at E0.
- Word w[NK+k] is written at edge E0+1+k.
- done is high in the cycle after edge E0+(4*NR+4-NK), i.e. 40 / 46 / 52 cycles after E0 for 128 / 192 / 256.
- Back-to-back: `start` may be asserted in the done cycle and is accepted, since busy=0.
- `rst` mid-GEN: the next cycle is IDLE with busy=0 and key_ready=0. The partial schedule is unreadable.
- `rst` and `start` in the same cycle: `rst` wins.
- rd_en during busy: rd_valid=0.
- rd_en in the done cycle: valid data on the following cycle.

## Configuration
- `AES_KEY_SCHED_REVERSE_EN` defined: adds input `rd_rev` (1 bit).
  - When `rd_rev`=1, the read uses round NR−rd_round, for decryption order.
  - Out-of-range detection (rd_round > NR) is applied before the inversion.
- Undefined: the port is absent and reads are always forward-indexed.

## Test plan
- KEY_BITS=128, key 2b7e1516 28aed2a6 abf71588 09cf4f3c, start → done 40 cycles later.
  - Read round 10 → d014f9a8 c9ee2589 e13f0cc8 b6630ca6.
  - Read round 0 → the key itself.
- KEY_BITS=192, key 8e73b0f7 da0e6452 c810f32b 809079e5 62f8ead2 522c6b7b → done after 46 cycles.
  - Round 12 → e98ba06f 448c773c 8ecc7204 01002202.
- KEY_BITS=256, key 603deb10 15ca71be 2b73aef0 857d7781 1f352c07 3b6108d7 2d9810a3 0914dff4 → done after 52 cycles.
  - Round 14 → fe4890d1 e6188d0b 046df344 706c631e (exercises the i mod 8 == 4 SubWord path).
- Boundaries:
  - Second start 5 cycles into GEN → ignored, and done timing is unchanged.
  - rd_round=11 with KEY_BITS=128 → rd_valid=0, rd_key=0.
  - rd_en while busy → rd_valid=0.
- rst at cycle 20 of GEN → busy=0, key_ready=0 next cycle.
  - A fresh start then completes with correct keys and rcon restarted at 01.
- REVERSE_EN, KEY_BITS=128: rd_rev=1, rd_round=0 → round-10 key.
  - Back-to-back reads of rounds 0..10 on consecutive cycles → 11 consecutive rd_valid pulses.

Source files
------------

// File: rtl/aes_key_sched_if.sv
// Handshake and round-key read bus of the iterative AES key-expansion engine.
// Defining AES_KEY_SCHED_REVERSE_EN adds rd_rev for decryption-order reads.
interface aes_key_sched_if;
    logic         start;
    logic [255:0] key_in;
    logic         busy;
    logic         done;
    logic         key_ready;
    logic         rd_en;
    logic [3:0]   rd_round;
    logic [127:0] rd_key;
    logic         rd_valid;
`ifdef AES_KEY_SCHED_REVERSE_EN
    logic         rd_rev;

    modport master (
        output start, key_in, rd_en, rd_round, rd_rev,
        input  busy, done, key_ready, rd_key, rd_valid
    );
    modport slave (
        input  start, key_in, rd_en, rd_round, rd_rev,
        output busy, done, key_ready, rd_key, rd_valid
    );
`else
    modport master (
        output start, key_in, rd_en, rd_round,
        input  busy, done, key_ready, rd_key, rd_valid
    );
    modport slave (
        input  start, key_in, rd_en, rd_round,
        output busy, done, key_ready, rd_key, rd_valid
    );
`endif
endinterface

// File: rtl/aes_key_sched.sv
// Iterative AES-128/192/256 key expansion: one schedule word per clock, full schedule
// kept in a word store with a registered round-key read port. AES_KEY_SCHED_REVERSE_EN adds rd_rev.
module aes_key_sched #(
    parameter int KEY_BITS = 128
) (
    input logic             clk,
    input logic             rst,
    aes_key_sched_if.slave  bus
);
    localparam int NK    = KEY_BITS / 32;
    localparam int NR    = NK + 6;
    localparam int WORDS = 4 * (NR + 1);
    localparam int LAST  = 4 * NR + 3;

    generate
        if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
            $error("aes_key_sched: KEY_BITS must be 128, 192 or 256");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, GEN, DONE} state_t;

    state_t      state, state_nxt;
    logic        accept, last, key_ready;
    logic [5:0]  idx;
    logic [2:0]  pos;
    logic [7:0]  rcon;
    logic [31:0] sh [NK];
    logic [31:0] mem [WORDS];
    logic [31:0] prev, oldw, sub_in, sub_out, t, new_word;
    logic [3:0]  rd_idx;
    logic        in_range;
    logic        unused_key;

    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] z);
        logic [7:0] p, a;
        p = 8'h00;
        a = x;
        for (int k = 0; k < 8; k++) begin
            if (z[k]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box as multiplicative inverse (x^254) followed by the affine transform.
    function automatic logic [7:0] sbox1(input logic [7:0] x);
        logic [7:0] sq, r;
        sq = x;
        r  = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    assign accept     = bus.start && (state != GEN);
    assign last       = (idx == 6'(LAST));
    assign prev       = sh[NK-1];
    assign oldw       = sh[0];
    assign unused_key = ^bus.key_in;
    assign bus.key_ready = key_ready;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (bus.start) state_nxt = GEN;
            GEN:     if (last) state_nxt = DONE;
            DONE:    state_nxt = bus.start ? GEN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state == GEN);
        bus.done = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx       <= '0;
            pos       <= '0;
            rcon      <= 8'h01;
            key_ready <= 1'b0;
        end else if (accept) begin
            idx       <= 6'(NK);
            pos       <= '0;
            rcon      <= 8'h01;
            key_ready <= 1'b0;
        end else if (state == GEN) begin
            idx <= idx + 6'd1;
            pos <= (pos == 3'(NK - 1)) ? 3'd0 : pos + 3'd1;
            if (pos == 3'd0) rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
            if (last) key_ready <= 1'b1;
        end
    end

    // The shadow window always holds w[i-NK] .. w[i-1], so the store is never read back here.
    always_comb begin
        sub_in  = {prev[23:0], prev[31:24]};
        if (NK == 8 && pos == 3'd4) sub_in = prev;
        sub_out = '0;
        for (int b = 0; b < 4; b++) sub_out[8*b +: 8] = sbox1(sub_in[8*b +: 8]);
        t = prev;
        if (pos == 3'd0)                 t = sub_out ^ {rcon, 24'h0};
        else if (NK == 8 && pos == 3'd4) t = sub_out;
        new_word = oldw ^ t;
    end

    always_ff @(posedge clk) begin
        if (!rst && accept) begin
            for (int j = 0; j < NK; j++) begin
                sh[j]  <= bus.key_in[255 - 32*j -: 32];
                mem[j] <= bus.key_in[255 - 32*j -: 32];
            end
        end else if (!rst && state == GEN) begin
            for (int j = 0; j < NK - 1; j++) sh[j] <= sh[j+1];
            sh[NK-1] <= new_word;
            mem[idx] <= new_word;
        end
    end

    // Range is judged on the requested index, before any reversal.
    always_comb begin
        in_range = (bus.rd_round <= 4'(NR));
`ifdef AES_KEY_SCHED_REVERSE_EN
        rd_idx = bus.rd_rev ? 4'(NR) - bus.rd_round : bus.rd_round;
`else
        rd_idx = bus.rd_round;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.rd_valid <= 1'b0;
            bus.rd_key   <= '0;
        end else if (bus.rd_en && key_ready && in_range) begin
            bus.rd_valid <= 1'b1;
            bus.rd_key   <= {mem[{rd_idx, 2'b00}], mem[{rd_idx, 2'b01}],
                             mem[{rd_idx, 2'b10}], mem[{rd_idx, 2'b11}]};
        end else begin
            bus.rd_valid <= 1'b0;
            bus.rd_key   <= '0;
        end
    end
endmodule

// File: tb/tb_aes_key_sched.sv
// Scoreboard bench for aes_key_sched: AES-128/192/256 instances driven with FIPS-197 vectors.
// Reverse-read cases are compiled in when AES_KEY_SCHED_REVERSE_EN is defined.
module tb_aes_key_sched;
    typedef struct {
        int           dut;
        int           tag;
        logic         valid;
        logic [127:0] key;
    } exp_t;

    logic         clk = 1'b0;
    logic [2:0]   rst_v, start_v, rd_en_v, pend;
    logic [255:0] key_v [3];
    logic [3:0]   rd_round_v [3];
    wire  [2:0]   busy_v, done_v, ready_v, rd_valid_v;
    wire  [383:0] rd_key_v;
`ifdef AES_KEY_SCHED_REVERSE_EN
    logic [2:0]   rd_rev_v;
`endif

    exp_t         exp_q[$];
    exp_t         e;
    int           checks = 0;
    int           passes = 0;
    int           tag_n  = 0;
    logic [127:0] rk128 [11];

    localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0123456789abcdeffedcba9876543210};
    localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'hffffffff00000000};
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        aes_key_sched_if bus ();
        assign bus.start    = start_v[g];
        assign bus.key_in   = key_v[g];
        assign bus.rd_en    = rd_en_v[g];
        assign bus.rd_round = rd_round_v[g];
`ifdef AES_KEY_SCHED_REVERSE_EN
        assign bus.rd_rev   = rd_rev_v[g];
`endif
        assign busy_v[g]     = bus.busy;
        assign done_v[g]     = bus.done;
        assign ready_v[g]    = bus.key_ready;
        assign rd_valid_v[g] = bus.rd_valid;
        assign rd_key_v[128*g +: 128] = bus.rd_key;
        aes_key_sched #(.KEY_BITS(128 + 64*g)) dut (.clk(clk), .rst(rst_v[g]), .bus(bus));
    end

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] expv);
        checks++;
        if (act === expv) passes++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, act, expv);
    endtask

    // Issue one read at the current negedge and advance one cycle; rd_en stays as left.
    task automatic readRound(input int d, input logic [3:0] r, input logic v, input logic [127:0] k);
        rd_en_v[d]    = 1'b1;
        rd_round_v[d] = r;
        exp_q.push_back('{dut: d, tag: tag_n, valid: v, key: k});
        tag_n++;
        @(negedge clk);
    endtask

    task automatic finishReads(input int d);
        rd_en_v[d] = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Start an expansion, poke a stray start and a busy-time read, then wait for done.
    task automatic applyStimulus(input int d, input logic [255:0] key, input int exp_cycles, input string name);
        int n;
        key_v[d]   = key;
        start_v[d] = 1'b1;
        @(negedge clk);
        start_v[d] = 1'b0;
        checkOutput({name, " busy after start"}, 128'(busy_v[d]), 128'd1);
        checkOutput({name, " key_ready after start"}, 128'(ready_v[d]), 128'd0);
        n = 0;
        while (!done_v[d] && n < 200) begin
            @(negedge clk);
            n++;
            if (n == 5) begin
                key_v[d]   = ~key;
                start_v[d] = 1'b1;
            end else if (n == 6) begin
                key_v[d]   = key;
                start_v[d] = 1'b0;
            end else if (n == 8) begin
                rd_en_v[d]    = 1'b1;
                rd_round_v[d] = 4'd0;
                exp_q.push_back('{dut: d, tag: tag_n, valid: 1'b0, key: 128'h0});
                tag_n++;
            end else if (n == 9) begin
                rd_en_v[d] = 1'b0;
            end
        end
        checkOutput({name, " cycles to done"}, 128'(n), 128'(exp_cycles));
        checkOutput({name, " busy at done"}, 128'(busy_v[d]), 128'd0);
        checkOutput({name, " key_ready at done"}, 128'(ready_v[d]), 128'd1);
    endtask

    always @(posedge clk) pend <= rd_en_v;

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (pend[d] === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("[TB] FAIL read dut%0d: got a response, expected no pending read", d);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput($sformatf("read dut%0d #%0d owner", d, e.tag), 128'(e.dut), 128'(d));
                    checkOutput($sformatf("rd_valid dut%0d #%0d", d, e.tag), 128'(rd_valid_v[d]), 128'(e.valid));
                    checkOutput($sformatf("rd_key dut%0d #%0d", d, e.tag), rd_key_v[128*d +: 128], e.key);
                end
            end else if (rd_valid_v[d] !== 1'b0) begin
                checks++;
                $display("[TB] FAIL rd_valid dut%0d idle: got %b, expected 0", d, rd_valid_v[d]);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rk128 = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
                  128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
                  128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
                  128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
                  128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
                  128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        rst_v   = 3'b111;
        start_v = 3'b000;
        rd_en_v = 3'b000;
`ifdef AES_KEY_SCHED_REVERSE_EN
        rd_rev_v = 3'b000;
`endif
        for (int d = 0; d < 3; d++) begin
            key_v[d]      = '0;
            rd_round_v[d] = 4'd0;
        end
        repeat (3) @(negedge clk);
        rst_v = 3'b000;
        for (int d = 0; d < 3; d++) begin
            checkOutput($sformatf("reset busy dut%0d", d), 128'(busy_v[d]), 128'd0);
            checkOutput($sformatf("reset done dut%0d", d), 128'(done_v[d]), 128'd0);
            checkOutput($sformatf("reset key_ready dut%0d", d), 128'(ready_v[d]), 128'd0);
            checkOutput($sformatf("reset rd_valid dut%0d", d), 128'(rd_valid_v[d]), 128'd0);
            checkOutput($sformatf("reset rd_key dut%0d", d), rd_key_v[128*d +: 128], 128'h0);
        end
        readRound(0, 4'd0, 1'b0, 128'h0);
        finishReads(0);

        // AES-128: read in the done cycle, then all rounds back to back, then out-of-range.
        applyStimulus(0, K128, 40, "aes128");
        readRound(0, 4'd10, 1'b1, rk128[10]);
        for (int r = 0; r <= 10; r++) readRound(0, 4'(r), 1'b1, rk128[r]);
        readRound(0, 4'd11, 1'b0, 128'h0);
        readRound(0, 4'd15, 1'b0, 128'h0);
`ifdef AES_KEY_SCHED_REVERSE_EN
        rd_rev_v[0] = 1'b1;
        readRound(0, 4'd0, 1'b1, rk128[10]);
        readRound(0, 4'd3, 1'b1, rk128[7]);
        readRound(0, 4'd10, 1'b1, rk128[0]);
        readRound(0, 4'd11, 1'b0, 128'h0);
        rd_rev_v[0] = 1'b0;
`endif
        finishReads(0);

        // Reset part way through generation, with a simultaneous start that must lose.
        key_v[0]   = K128;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (19) @(negedge clk);
        rst_v[0]   = 1'b1;
        start_v[0] = 1'b1;
        @(negedge clk);
        rst_v[0]   = 1'b0;
        start_v[0] = 1'b0;
        checkOutput("rst mid-gen busy", 128'(busy_v[0]), 128'd0);
        checkOutput("rst mid-gen key_ready", 128'(ready_v[0]), 128'd0);
        readRound(0, 4'd0, 1'b0, 128'h0);
        checkOutput("rst mid-gen still idle", 128'(busy_v[0]), 128'd0);
        finishReads(0);
        applyStimulus(0, K128, 40, "aes128 after rst");
        readRound(0, 4'd1, 1'b1, rk128[1]);
        readRound(0, 4'd10, 1'b1, rk128[10]);
        finishReads(0);

        // AES-192, restarted in its own done cycle.
        applyStimulus(1, K192, 46, "aes192");
        applyStimulus(1, K192, 46, "aes192 back-to-back");
        readRound(1, 4'd12, 1'b1, 128'he98ba06f448c773c8ecc720401002202);
        readRound(1, 4'd0, 1'b1, 128'h8e73b0f7da0e6452c810f32b809079e5);
        readRound(1, 4'd1, 1'b1, 128'h62f8ead2522c6b7bfe0c91f72402f5a5);
        readRound(1, 4'd13, 1'b0, 128'h0);
        finishReads(1);

        // AES-256: rounds 2/3 and 14 cover the extra SubWord at i mod 8 == 4.
        applyStimulus(2, K256, 52, "aes256");
        readRound(2, 4'd14, 1'b1, 128'hfe4890d1e6188d0b046df344706c631e);
        checkOutput("aes256 done pulse width", 128'(done_v[2]), 128'd0);
        readRound(2, 4'd2, 1'b1, 128'h9ba354118e6925afa51a8b5f2067fcde);
        readRound(2, 4'd3, 1'b1, 128'ha8b09c1a93d194cdbe49846eb75d5b9a);
        readRound(2, 4'd1, 1'b1, 128'h1f352c073b6108d72d9810a30914dff4);
        readRound(2, 4'd15, 1'b0, 128'h0);
        finishReads(2);

        repeat (2) @(negedge clk);
        checkOutput("scoreboard drained", 128'(exp_q.size()), 128'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
